// File: rtl/hpi_pkg.sv
// ------------------------------------------------------------------
// hpi_pkg : HPI register map, responder states, STATUS bit positions
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDRESS = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ACT = 2'd1,
    WR_ACT = 2'd2
  } hpi_state_e;

  localparam int STAT_MBX_OUT = 0;
  localparam int STAT_MBX_IN  = 1;

endpackage

`default_nettype wire

// File: rtl/hpi_strobe_sync.sv
// ------------------------------------------------------------------
// hpi_strobe_sync : multi-flop synchronizer with rise/fall pulses
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hpi_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic act_raw,
  output logic act,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], act_raw};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign act  = r_sync[STAGES-1];
  assign rise = act & ~r_prev;
  assign fall = ~act & r_prev;

endmodule

`default_nettype wire

// File: rtl/hpi_device_responder.sv
// ------------------------------------------------------------------
// hpi_device_responder : device-side CY7C67200 HPI model (memory, mailboxes, STATUS, INT)
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hpi_device_responder
  import hpi_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         Clk,
  input  logic                         reset_n,
  input  logic [1:0]                   hpi_addr,
  input  logic                         hpi_cs_n,
  input  logic                         hpi_rd_n,
  input  logic                         hpi_wr_n,
  input  logic [15:0]                  hpi_din,
  output logic [15:0]                  hpi_dout,
  output logic                         hpi_doe,
  output logic                         hpi_int,
  input  logic                         loc_we,
  input  logic [$clog2(MEM_WORDS)-1:0] loc_addr,
  input  logic [15:0]                  loc_wdata,
  output logic                         loc_ready,
  input  logic                         mbx_out_wr,
  input  logic [15:0]                  mbx_out_data,
  output logic [15:0]                  mbx_in_data,
  output logic                         mbx_in_valid,
  input  logic                         mbx_in_ack
);

  localparam int AW = $clog2(MEM_WORDS);

  logic w_rd_raw, w_rd_act, w_rd_rise, w_rd_fall;
  logic w_wr_raw, w_wr_act, w_wr_rise, w_wr_fall;

  assign w_rd_raw = ~hpi_cs_n & ~hpi_rd_n;
  assign w_wr_raw = ~hpi_cs_n & ~hpi_wr_n;

  hpi_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(Clk), .rst_n(reset_n), .act_raw(w_rd_raw),
    .act(w_rd_act), .rise(w_rd_rise), .fall(w_rd_fall)
  );

  hpi_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(Clk), .rst_n(reset_n), .act_raw(w_wr_raw),
    .act(w_wr_act), .rise(w_wr_rise), .fall(w_wr_fall)
  );

  hpi_state_e r_state, w_next;
  logic       w_rd_start, w_rd_done, w_wr_start, w_wr_commit;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // A read rise wins over a simultaneous write rise.
  always_comb begin
    w_next      = r_state;
    w_rd_start  = 1'b0;
    w_rd_done   = 1'b0;
    w_wr_start  = 1'b0;
    w_wr_commit = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rd_rise) begin
          w_next     = RD_ACT;
          w_rd_start = 1'b1;
        end else if (w_wr_rise && !w_rd_act) begin
          w_next     = WR_ACT;
          w_wr_start = 1'b1;
        end
      end
      RD_ACT: if (w_rd_fall) begin
        w_next    = IDLE;
        w_rd_done = 1'b1;
      end
      WR_ACT: if (w_wr_fall) begin
        w_next      = IDLE;
        w_wr_commit = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  hpi_reg_e      r_addr;
  logic [15:0]   r_wdata, r_ptr, r_dout, r_mbx_out, r_rd_word, r_mbx_in;
  logic          r_dout_mem, r_out_full, r_in_valid;
  logic [15:0]   w_status, w_ptr_next;
  logic [AW:0]   w_ptr_low;
  logic [AW-1:0] w_ptr_idx;
  logic          w_data_step, w_host_mem_wr;

  always_comb begin
    w_status               = '0;
    w_status[STAT_MBX_OUT] = r_out_full;
    w_status[STAT_MBX_IN]  = r_in_valid;
  end

  // Pointer is a byte address; only the low AW+1 bits survive an increment.
  assign w_ptr_idx     = r_ptr[AW:1];
  assign w_ptr_low     = r_ptr[AW:0] + (AW+1)'(2);
  assign w_ptr_next    = {{(15-AW){1'b0}}, w_ptr_low};
  assign w_data_step   = (w_rd_done || w_wr_commit) && (r_addr == HPI_DATA);
  assign w_host_mem_wr = w_wr_commit && (r_addr == HPI_DATA);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= HPI_DATA;
      r_wdata    <= '0;
      r_ptr      <= '0;
      r_dout     <= '0;
      r_dout_mem <= 1'b0;
      r_mbx_out  <= '0;
      r_out_full <= 1'b0;
      r_mbx_in   <= '0;
      r_in_valid <= 1'b0;
    end else begin
      if (w_rd_start || w_wr_start) r_addr <= hpi_reg_e'(hpi_addr);
      if (w_wr_start || (r_state == WR_ACT && w_wr_act)) r_wdata <= hpi_din;

      if (w_rd_start) begin
        r_dout_mem <= (hpi_reg_e'(hpi_addr) == HPI_DATA);
        unique case (hpi_reg_e'(hpi_addr))
          HPI_MAILBOX: r_dout <= r_mbx_out;
          HPI_ADDRESS: r_dout <= r_ptr;
          HPI_STATUS:  r_dout <= w_status;
          default:     r_dout <= '0;
        endcase
      end

      if (w_data_step) r_ptr <= w_ptr_next;
      else if (w_wr_commit && r_addr == HPI_ADDRESS) r_ptr <= r_wdata;

      if (w_wr_commit && r_addr == HPI_MAILBOX) begin
        r_mbx_in   <= r_wdata;
        r_in_valid <= 1'b1;
      end else if (mbx_in_ack) begin
        r_in_valid <= 1'b0;
      end

      if (mbx_out_wr) begin
        r_mbx_out  <= mbx_out_data;
        r_out_full <= 1'b1;
      end else if (w_rd_done && r_addr == HPI_MAILBOX) begin
        r_out_full <= 1'b0;
      end
    end
  end

  logic [15:0] r_mem [MEM_WORDS];

  // Read-before-write: a same-cycle local write is not seen by the host read.
  always_ff @(posedge Clk) begin
    if (w_host_mem_wr)   r_mem[w_ptr_idx] <= r_wdata;
    else if (loc_we)     r_mem[loc_addr]  <= loc_wdata;
    if (w_rd_start)      r_rd_word        <= r_mem[w_ptr_idx];
  end

  assign hpi_dout     = r_dout_mem ? r_rd_word : r_dout;
  assign hpi_doe      = (r_state == RD_ACT) && w_rd_act;
  assign hpi_int      = r_out_full;
  assign loc_ready    = ~w_host_mem_wr;
  assign mbx_in_data  = r_mbx_in;
  assign mbx_in_valid = r_in_valid;

endmodule

`default_nettype wire

// File: tb/tb_hpi_device_responder.sv
// ------------------------------------------------------------------
// tb_hpi_device_responder : vector table, corner sequences, random ops vs transaction model
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_hpi_device_responder;

  localparam int MEM_WORDS = 256;
  localparam int BYTE_SPAN = 2 * MEM_WORDS;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_rd_n, hpi_wr_n;
  logic [15:0] hpi_din, hpi_dout;
  logic        hpi_doe, hpi_int;
  logic        loc_we;
  logic [7:0]  loc_addr;
  logic [15:0] loc_wdata;
  logic        loc_ready;
  logic        mbx_out_wr;
  logic [15:0] mbx_out_data, mbx_in_data;
  logic        mbx_in_valid, mbx_in_ack;

  always #5 Clk = ~Clk;

  hpi_device_responder #(.MEM_WORDS(MEM_WORDS), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .reset_n(reset_n), .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n),
    .hpi_rd_n(hpi_rd_n), .hpi_wr_n(hpi_wr_n), .hpi_din(hpi_din), .hpi_dout(hpi_dout),
    .hpi_doe(hpi_doe), .hpi_int(hpi_int), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_ready(loc_ready), .mbx_out_wr(mbx_out_wr),
    .mbx_out_data(mbx_out_data), .mbx_in_data(mbx_in_data), .mbx_in_valid(mbx_in_valid),
    .mbx_in_ack(mbx_in_ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference state.
  logic [15:0] m_mem [MEM_WORDS];
  logic [15:0] m_ptr, m_mbx_out, m_in_data;
  logic        m_out_full, m_in_valid;

  typedef struct {
    bit          wr;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = '0; m_mbx_out = '0; m_in_data = '0; m_out_full = 1'b0; m_in_valid = 1'b0;
  endfunction

  function automatic logic [15:0] model_op(input bit wr, input logic [1:0] a, input logic [15:0] d);
    int          base = int'(m_ptr) % BYTE_SPAN;
    int          idx  = base / 2;
    logic [15:0] r    = '0;
    case (a)
      2'd0: begin
        if (wr) m_mem[idx] = d; else r = m_mem[idx];
        m_ptr = 16'((base + 2) % BYTE_SPAN);
      end
      2'd1: if (wr) begin m_in_data = d; m_in_valid = 1'b1; end
            else begin r = m_mbx_out; m_out_full = 1'b0; end
      2'd2: if (wr) m_ptr = d; else r = m_ptr;
      default: if (!wr) r = {14'b0, m_in_valid, m_out_full};
    endcase
    return r;
  endfunction

  task automatic host_op(input bit wr, input logic [1:0] a, input logic [15:0] d,
                         output logic [15:0] rdata);
    int n;
    rdata = '0;
    @(negedge Clk);
    hpi_addr = a;
    if (wr) begin
      hpi_din = d; hpi_cs_n = 1'b0; hpi_wr_n = 1'b0;
      repeat (4) @(negedge Clk);
      hpi_cs_n = 1'b1; hpi_wr_n = 1'b1;
      repeat (6) @(negedge Clk);
    end else begin
      hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
      n = 0;
      while (hpi_doe !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
      check("rd_doe_assert", 16'(hpi_doe), 16'd1);
      rdata = hpi_dout;
      hpi_cs_n = 1'b1; hpi_rd_n = 1'b1;
      n = 0;
      while (hpi_doe !== 1'b0 && n < 20) begin @(negedge Clk); n++; end
      check("rd_doe_release", 16'(hpi_doe), 16'd0);
      repeat (3) @(negedge Clk);
    end
  endtask

  task automatic do_op(input bit wr, input logic [1:0] a, input logic [15:0] d,
                       output logic [15:0] got, output logic [15:0] exp);
    exp = model_op(wr, a, d);
    host_op(wr, a, d, got);
  endtask

  task automatic post_out(input logic [15:0] d);
    @(negedge Clk); mbx_out_wr = 1'b1; mbx_out_data = d;
    @(negedge Clk); mbx_out_wr = 1'b0;
    m_mbx_out = d; m_out_full = 1'b1;
  endtask

  task automatic ack_in();
    @(negedge Clk); mbx_in_ack = 1'b1;
    @(negedge Clk); mbx_in_ack = 1'b0;
    m_in_valid = 1'b0;
  endtask

  task automatic loc_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge Clk); loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    @(negedge Clk); loc_we = 1'b0;
    m_mem[a] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got, exp;
    int          n;

    reset_n = 1'b0; hpi_addr = '0; hpi_cs_n = 1'b1; hpi_rd_n = 1'b1; hpi_wr_n = 1'b1;
    hpi_din = '0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    mbx_out_wr = 1'b0; mbx_out_data = '0; mbx_in_ack = 1'b0;
    model_reset();
    #12;
    check("rst_dout", hpi_dout, 16'h0000);
    check("rst_doe", 16'(hpi_doe), 16'd0);
    check("rst_int", 16'(hpi_int), 16'd0);
    check("rst_loc_ready", 16'(loc_ready), 16'd1);
    check("rst_mbx_in_data", mbx_in_data, 16'h0000);
    check("rst_mbx_in_valid", 16'(mbx_in_valid), 16'd0);
    @(negedge Clk); reset_n = 1'b1;

    for (int i = 0; i < MEM_WORDS; i++) loc_write(8'(i), 16'(i * 16'h0101) ^ 16'h5A00);

    // Read latency: doe seen after SYNC_STAGES+1 clocks.
    @(negedge Clk); hpi_addr = 2'd3; hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
    n = 0;
    while (hpi_doe !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
    check("rd_latency", 16'(n), 16'd3);
    check("status_after_reset", hpi_dout, 16'h0000);
    hpi_cs_n = 1'b1; hpi_rd_n = 1'b1;
    check("doe_drop", 16'(hpi_doe), 16'd1);
    repeat (3) @(negedge Clk);
    check("doe_low", 16'(hpi_doe), 16'd0);

    // Write commit latency, seen through mbx_in_valid.
    hpi_addr = 2'd1; hpi_din = 16'h0077; hpi_cs_n = 1'b0; hpi_wr_n = 1'b0;
    repeat (4) @(negedge Clk);
    hpi_cs_n = 1'b1; hpi_wr_n = 1'b1;
    repeat (2) @(negedge Clk);
    check("wr_latency_early", 16'(mbx_in_valid), 16'd0);
    @(negedge Clk);
    check("wr_latency_commit", 16'(mbx_in_valid), 16'd1);
    check("wr_latency_data", mbx_in_data, 16'h0077);
    m_in_data = 16'h0077; m_in_valid = 1'b1;
    ack_in();
    check("ack_clears", 16'(mbx_in_valid), 16'd0);

    tbl.push_back('{1'b1, 2'd2, 16'h0010, 16'h0000});
    tbl.push_back('{1'b1, 2'd0, 16'hBEEF, 16'h0000});
    tbl.push_back('{1'b1, 2'd0, 16'h1234, 16'h0000});
    tbl.push_back('{1'b1, 2'd2, 16'h0010, 16'h0000});
    tbl.push_back('{1'b0, 2'd0, 16'h0000, 16'hBEEF});
    tbl.push_back('{1'b0, 2'd0, 16'h0000, 16'h1234});
    tbl.push_back('{1'b0, 2'd2, 16'h0000, 16'h0014});
    tbl.push_back('{1'b1, 2'd2, 16'h01FE, 16'h0000});
    tbl.push_back('{1'b1, 2'd0, 16'hAAAA, 16'h0000});
    tbl.push_back('{1'b0, 2'd2, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 2'd2, 16'h01FE, 16'h0000});
    tbl.push_back('{1'b0, 2'd0, 16'h0000, 16'hAAAA});
    tbl.push_back('{1'b0, 2'd2, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 2'd3, 16'hFFFF, 16'h0000});
    tbl.push_back('{1'b0, 2'd3, 16'h0000, 16'h0000});
    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].wr, tbl[i].a, tbl[i].d, got, exp);
      if (!tbl[i].wr) check($sformatf("tbl%0d", i), got, tbl[i].exp);
    end

    // Mailbox out: post raises INT and STATUS bit0; host read clears both.
    post_out(16'h5A5A);
    check("post_int", 16'(hpi_int), 16'd1);
    do_op(1'b0, 2'd3, 16'h0, got, exp); check("post_status", got, 16'h0001);
    do_op(1'b0, 2'd1, 16'h0, got, exp); check("mbx_read", got, 16'h5A5A);
    check("mbx_read_int", 16'(hpi_int), 16'd0);
    do_op(1'b0, 2'd3, 16'h0, got, exp); check("mbx_read_status", got, 16'h0000);

    // Mailbox in.
    do_op(1'b1, 2'd1, 16'h00C3, got, exp);
    check("mbx_in_valid", 16'(mbx_in_valid), 16'd1);
    check("mbx_in_data", mbx_in_data, 16'h00C3);
    do_op(1'b0, 2'd3, 16'h0, got, exp); check("mbx_in_status", got, 16'h0002);
    ack_in();
    check("mbx_in_ack", 16'(mbx_in_valid), 16'd0);

    // Local write colliding with host DATA commit to word 8.
    do_op(1'b1, 2'd2, 16'h0010, got, exp);
    exp = model_op(1'b1, 2'd0, 16'h1111);
    @(negedge Clk); hpi_addr = 2'd0; hpi_din = 16'h1111; hpi_cs_n = 1'b0; hpi_wr_n = 1'b0;
    repeat (4) @(negedge Clk);
    hpi_cs_n = 1'b1; hpi_wr_n = 1'b1;
    repeat (2) @(negedge Clk);
    loc_we = 1'b1; loc_addr = 8'd8; loc_wdata = 16'h2222;
    #1 check("collide_not_ready", 16'(loc_ready), 16'd0);
    @(negedge Clk);
    check("collide_ready_next", 16'(loc_ready), 16'd1);
    @(negedge Clk); loc_we = 1'b0;
    m_mem[8] = 16'h2222;
    do_op(1'b0, 2'd2, 16'h0, got, exp); check("collide_ptr", got, 16'h0012);
    do_op(1'b1, 2'd2, 16'h0010, got, exp);
    do_op(1'b0, 2'd0, 16'h0, got, exp); check("collide_word8", got, 16'h2222);

    // Reset in the middle of a read.
    do_op(1'b1, 2'd2, 16'h0040, got, exp);
    post_out(16'h0F0F);
    @(negedge Clk); hpi_addr = 2'd2; hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
    n = 0;
    while (hpi_doe !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
    check("midrd_doe", 16'(hpi_doe), 16'd1);
    reset_n = 1'b0;
    #1 check("midrd_doe_reset", 16'(hpi_doe), 16'd0);
    @(negedge Clk); hpi_cs_n = 1'b1; hpi_rd_n = 1'b1;
    repeat (3) @(negedge Clk); reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge Clk);
    check("midrd_int", 16'(hpi_int), 16'd0);
    do_op(1'b0, 2'd2, 16'h0, got, exp); check("midrd_ptr", got, 16'h0000);

    // Random host/device traffic against the reference.
    for (int i = 0; i < 80; i++) begin
      int   ev;
      bit   wr;
      logic [1:0] a;
      ev = $urandom_range(0, 9);
      if (ev < 2)      post_out(16'($urandom));
      else if (ev < 3) ack_in();
      else if (ev < 5) loc_write(8'($urandom), 16'($urandom));
      wr = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      do_op(wr, a, 16'($urandom), got, exp);
      if (!wr) check($sformatf("rnd%0d_rd%0d", i, a), got, exp);
      check($sformatf("rnd%0d_int", i), 16'(hpi_int), 16'(m_out_full));
      check($sformatf("rnd%0d_valid", i), 16'(mbx_in_valid), 16'(m_in_valid));
      if (m_in_valid) check($sformatf("rnd%0d_in", i), mbx_in_data, m_in_data);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
